// File: rtl/hazard_unit_v3.sv
// rtl/hazard_unit_v3.sv - stateful 5-stage hazard unit: forwarding, load-use stall, branch flush, dmem freeze
module hazard_unit_v3 #(
    parameter int REG_AW      = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regw,
    input  logic              id_load,
    input  logic              ex_pcsel,
    input  logic              regw_in,
    input  logic              dmemw_in,
    input  logic              dmem_busy,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              bubble_x,
    output logic              pcsel_out,
    output logic              regw_out,
    output logic              dmemw_out
);

    logic              x_valid, x_regw, x_load;
    logic [REG_AW-1:0] x_rs1, x_rs2, x_rd;
    logic [REG_AW-1:0] m_rd, w_rd;
    logic              m_regw, w_regw;
    logic [CNT_W-1:0]  flush_cnt;

    logic flushing, pcsel_raw, load_use, bubble_raw, x_next_valid;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (m_regw && m_rd != '0 && m_rd == src)
            fwd_sel = 2'b01;
        else if (w_regw && w_rd != '0 && w_rd == src)
            fwd_sel = 2'b10;
        else
            fwd_sel = 2'b00;
    endfunction

    always_comb begin
        flushing     = (flush_cnt != '0);
        pcsel_raw    = !dmem_busy && !flushing && ex_pcsel && x_valid;
        load_use     = x_load && x_regw && (x_rd != '0) && id_valid &&
                       ((x_rd == id_rs1) || (x_rd == id_rs2));
        bubble_raw   = !dmem_busy && (pcsel_raw || load_use);
        x_next_valid = id_valid && !bubble_raw && !flushing;
    end

    // Every output is forced low during reset, even if dmem_busy is high.
    always_comb begin
        fwd_a     = rst_n ? fwd_sel(x_rs1) : 2'b00;
        fwd_b     = rst_n ? fwd_sel(x_rs2) : 2'b00;
        stall_f   = rst_n && (dmem_busy || (load_use && !pcsel_raw));
        stall_d   = stall_f;
        flush_d   = rst_n && !dmem_busy && (pcsel_raw || flushing);
        bubble_x  = rst_n && bubble_raw;
        pcsel_out = rst_n && pcsel_raw;
        regw_out  = rst_n && regw_in && x_valid;
        dmemw_out = rst_n && dmemw_in && x_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_valid   <= 1'b0;
            x_rs1     <= '0;
            x_rs2     <= '0;
            x_rd      <= '0;
            x_regw    <= 1'b0;
            x_load    <= 1'b0;
            m_rd      <= '0;
            m_regw    <= 1'b0;
            w_rd      <= '0;
            w_regw    <= 1'b0;
            flush_cnt <= '0;
        end else if (!dmem_busy) begin
            w_rd    <= m_rd;
            w_regw  <= m_regw;
            m_rd    <= x_rd;
            m_regw  <= x_regw;
            x_valid <= x_next_valid;
            x_rs1   <= id_rs1;
            x_rs2   <= id_rs2;
            x_rd    <= id_rd;
            x_regw  <= id_regw && x_next_valid;
            x_load  <= id_load && x_next_valid;
            // The redirect edge kills the ID instruction itself, so only FLUSH_DEPTH-1 remain.
            if (pcsel_raw)
                flush_cnt <= CNT_W'(FLUSH_DEPTH - 1);
            else if (flushing)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_v3.sv
// tb/tb_hazard_unit_v3.sv - randomized and directed self-checking bench for hazard_unit_v3
module tb_hazard_unit_v3;

    localparam int FD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_regw, id_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_pcsel, regw_in, dmemw_in, dmem_busy;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, flush_d, bubble_x, pcsel_out, regw_out, dmemw_out;

    hazard_unit_v3 #(.REG_AW(5), .FLUSH_DEPTH(FD), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regw(id_regw), .id_load(id_load), .ex_pcsel(ex_pcsel),
        .regw_in(regw_in), .dmemw_in(dmemw_in), .dmem_busy(dmem_busy),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .bubble_x(bubble_x), .pcsel_out(pcsel_out),
        .regw_out(regw_out), .dmemw_out(dmemw_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       regw, load;
    } ins_t;

    ins_t stage[3];
    int   kills_left;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input bit [4:0] src);
        for (int s = 1; s <= 2; s++)
            if (stage[s].v && stage[s].regw && stage[s].rd != 0 && stage[s].rd == src)
                return s;
        return 0;
    endfunction

    function automatic bit ref_taken();
        return !dmem_busy && kills_left == 0 && ex_pcsel && stage[0].v;
    endfunction

    function automatic bit ref_lu();
        return stage[0].v && stage[0].load && stage[0].regw && stage[0].rd != 0 && id_valid &&
               (stage[0].rd == id_rs1 || stage[0].rd == id_rs2);
    endfunction

    task automatic compare_all();
        bit tk, lu, r;
        r  = rst_n;
        tk = ref_taken();
        lu = ref_lu();
        chk("fwd_a",    int'(fwd_a),     r ? ref_fwd(stage[0].rs1) : 0);
        chk("fwd_b",    int'(fwd_b),     r ? ref_fwd(stage[0].rs2) : 0);
        chk("stall_f",  int'(stall_f),   int'(r && (dmem_busy || (lu && !tk))));
        chk("stall_d",  int'(stall_d),   int'(r && (dmem_busy || (lu && !tk))));
        chk("flush_d",  int'(flush_d),   int'(r && !dmem_busy && (tk || kills_left > 0)));
        chk("bubble_x", int'(bubble_x),  int'(r && !dmem_busy && (tk || lu)));
        chk("pcsel",    int'(pcsel_out), int'(r && tk));
        chk("regw_out", int'(regw_out),  int'(r && regw_in && stage[0].v));
        chk("dmemw",    int'(dmemw_out), int'(r && dmemw_in && stage[0].v));
    endtask

    task automatic advance_model();
        bit tk, lu;
        tk = ref_taken();
        lu = ref_lu();
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) stage[s] = '{default: 0};
            kills_left = 0;
        end else if (!dmem_busy) begin
            stage[2] = stage[1];
            stage[1] = stage[0];
            stage[0] = '{v: id_valid && !tk && !lu && kills_left == 0,
                         rs1: id_rs1, rs2: id_rs2, rd: id_rd, regw: id_regw, load: id_load};
            if (tk) kills_left = FD - 1;
            else if (kills_left > 0) kills_left--;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        advance_model();
        #1;
    endtask

    task automatic set_id(input bit v, input bit [4:0] a, input bit [4:0] b, input bit [4:0] d,
                          input bit w, input bit l);
        id_valid = v; id_rs1 = a; id_rs2 = b; id_rd = d; id_regw = w; id_load = l;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0);
        ex_pcsel = 0; regw_in = 0; dmemw_in = 0; dmem_busy = 0;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) stage[s] = '{default: 0};
        kills_left = 0;

        // Reset with random inputs: outputs must all be 0.
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            ex_pcsel = 1'($urandom); regw_in = 1'($urandom);
            dmemw_in = 1'($urandom); dmem_busy = 1'($urandom);
            #1;
            chk("rst_stall", int'(stall_f), 0);
            step();
        end
        rst_n = 1; idle(); #1;
        chk("rst_fwd", int'({fwd_a, fwd_b}), 0);
        step();

        // ALU back-to-back, one-gap, and x0 forwarding.
        set_id(1, 0, 0, 5, 1, 0); step();
        set_id(1, 5, 5, 6, 1, 0); step();
        idle(); #1;
        chk("alu_m_a", int'(fwd_a), 1); chk("alu_m_b", int'(fwd_b), 1);
        set_id(1, 0, 0, 5, 1, 0); step();
        set_id(1, 9, 9, 1, 0, 0); step();
        set_id(1, 5, 5, 6, 1, 0); step();
        idle(); #1;
        chk("alu_w_a", int'(fwd_a), 2); chk("alu_w_b", int'(fwd_b), 2);
        set_id(1, 0, 0, 0, 1, 0); step();
        set_id(1, 0, 0, 7, 1, 0); step();
        idle(); #1;
        chk("x0_fwd", int'({fwd_a, fwd_b}), 0);

        // Load-use: one stall cycle, bubble never writes, then W forwarding.
        set_id(1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 1, 8, 1, 0); regw_in = 1; #1;
        chk("lu_stall", int'({stall_f, stall_d, bubble_x}), 7);
        step(); #1;
        chk("lu_once", int'(stall_f), 0);
        chk("lu_bub_regw", int'(regw_out), 0);
        step(); #1;
        chk("lu_fwd", int'(fwd_a), 2);
        idle();

        // Taken branch: two killed instructions, pcsel during flush ignored.
        set_id(1, 0, 0, 3, 1, 0); step();
        set_id(1, 1, 2, 4, 1, 0); ex_pcsel = 1; regw_in = 1; dmemw_in = 1; #1;
        chk("br_pcsel", int'(pcsel_out), 1); chk("br_flush", int'(flush_d), 1);
        step(); #1;
        chk("br_kill1", int'({regw_out, dmemw_out, pcsel_out}), 0);
        step(); #1;
        chk("br_kill2", int'({regw_out, dmemw_out}), 0);
        ex_pcsel = 0;
        step(); #1;
        chk("br_alive", int'(regw_out), 1);
        idle();

        // dmem_busy during an active flush.
        set_id(1, 0, 0, 3, 1, 0); step();
        ex_pcsel = 1; step();
        ex_pcsel = 0; dmem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("busy_stall", int'({stall_f, stall_d, pcsel_out, flush_d}), 12);
            step();
        end
        dmem_busy = 0; #1;
        chk("busy_flush_hold", int'(flush_d), 1);
        step(); #1;
        chk("busy_flush_done", int'(flush_d), 0);
        idle();

        // Simultaneous branch and load-use.
        set_id(1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 0, 8, 1, 0); ex_pcsel = 1; #1;
        chk("both_sig", int'({flush_d, stall_d, pcsel_out}), 5);
        step(); ex_pcsel = 0; #1;
        chk("both_nostall", int'(stall_d), 0);
        idle(); step(); step();

        // Randomized run against the reference model.
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            ex_pcsel  = ($urandom_range(0, 5) == 0);
            regw_in   = 1'($urandom);
            dmemw_in  = 1'($urandom);
            dmem_busy = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
